host_read_port: RTL and testbench
=================================

# host_read_port

Byte-wide responder that lets an external host (the Arduino-side controller) read back the processor's data memory. The host sends a 3-byte read command; the block issues one read on the shared vector memory port (same 18-bit address / 16×32-bit line / vector-scalar convention the CPU uses toward `mem_control`). It then streams the returned data back one byte at a time, either 4 bytes for a scalar read or 64 for a vector read. It sits beside the CPU on the memory side, in the `clk` domain.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 256: maximum cycles `mem_req` waits for `mem_ack` before aborting.
- `ERR_BYTE`, default 8'hEE: byte returned on timeout.

Ports:

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  host command byte present.
- `rx_data`  in  8  host command byte.
- `rx_ready`  out  1  block accepts command byte (transfer = `rx_valid & rx_ready`).
- `tx_valid`  out  1  response byte present.
- `tx_data`  out  8  response byte.
- `tx_ready`  in  1  host accepts response byte (transfer = `tx_valid & tx_ready`).
- `mem_req`  out  1  read request to the memory port.
- `mem_addr`  out  18  read address.
- `mem_vec`  out  1  1 = vector (16-lane) read, 0 = scalar (lane 0 only).
- `mem_ack`  in  1  read data valid this cycle.
- `mem_rdata`  in  16×32  read line; lane i = `mem_rdata[i]`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on a timeout abort.

## Operation

States:

- **IDLE**: `rx_ready` = 1. Accepts byte 0 and latches `vec` = `rx_data[7]` and `addr[17:16]` = `rx_data[1:0]`. Bits [6:2] are ignored. Goes to ADDR_HI.
- **ADDR_HI**: `rx_ready` = 1. Accepts byte 1, which becomes `addr[15:8]`. Goes to ADDR_LO.
- **ADDR_LO**: `rx_ready` = 1. Accepts byte 2, which becomes `addr[7:0]`. Goes to REQ.
- **REQ**:
  - `mem_req` = 1; `mem_addr` and `mem_vec` are held stable.
  - When `mem_ack` = 1: capture `mem_rdata` into the line buffer, clear the byte counter, go to SEND.
  - If a timeout expires first: go to SEND_ERR and pulse `err`.
- **SEND**:
  - `tx_valid` = 1 and `tx_data` = buffer byte k.
  - Byte k is lane k/4, bits [8·(k%4)+7 : 8·(k%4)]. This is lane 0 first, little-endian within each word.
  - k increments on each transfer.
  - After the last byte (k = 3 for scalar, k = 63 for vector) is transferred, go to IDLE.
- **SEND_ERR**: `tx_valid` = 1 and `tx_data` = `ERR_BYTE`. After one transfer, go to IDLE.

Rules and boundary conditions:

- `rx_ready` = 0 in REQ, SEND and SEND_ERR. `rx_valid` is ignored there and never queued.
- Without `tx_ready`, `tx_valid` and `tx_data` stay stable. The block never drops a response byte.
- The timeout counter clears on entry to REQ and increments each REQ cycle with `mem_ack` = 0. Abort happens on the edge that ends the `TIMEOUT_CYCLES`-th such cycle.
- If `mem_ack` arrives in that same final cycle, the ack wins and data is returned normally.
- `mem_ack` outside REQ is ignored.
- The byte counter is 6 bits. No wrap-around is exposed, because the terminal count forces IDLE.
- Reset (asynchronous, any state, including mid-SEND or mid-REQ):
  - State returns to IDLE.
  - `rx_ready` = 1 is the IDLE value after release; every other output is 0: `tx_valid`, `tx_data`, `mem_req`, `mem_addr`, `mem_vec`, `busy`, `err`.
  - Counters and the buffer clear.
  - A partial command or partial response is discarded.

## Timing

- Each command byte is accepted in one cycle when `rx_valid` is high. Back-to-back bytes can be accepted on consecutive edges.
- `mem_req` rises in the cycle after the byte-2 acceptance edge.
- `mem_req` falls in the cycle after the `mem_ack` edge. The ack cycle itself still shows `mem_req` = 1.
- First `tx_valid` appears in the cycle after the `mem_ack` edge.
- With `tx_ready` held high, throughput is one byte per cycle:
  - Scalar: 4 bytes in 4 cycles.
  - Vector: 64 bytes in 64 cycles.
- Best-case scalar command-to-last-byte time is 3 + 1 (ack) + 4 = 8 cycles.
- IDLE is re-entered on the edge that completes the final transfer. `rx_ready` = 1 in the next cycle.
- `err` is high for exactly the first SEND_ERR cycle.

## Test plan

- **Scalar read**: bytes 0x02, 0x12, 0x34; memory acks after 3 cycles with lane0 = 0xDEADBEEF.
  - `mem_addr` = 0x21234, `mem_vec` = 0.
  - `tx_data` sequence EF, BE, AD, DE; then IDLE.
- **Vector read**: bytes 0x80, 0x00, 0x10; lane i = 0x01010101·i; `tx_ready` held high.
  - 64 consecutive bytes, where byte k = k/4.
  - `busy` falls after byte 63.
- **Backpressure**: vector read with `tx_ready` toggling 1 cycle high / 2 low.
  - `tx_data` is stable across stalls; 64 bytes arrive with none lost or duplicated.
- **Timeout**: `TIMEOUT_CYCLES` = 8, memory never acks.
  - `mem_req` is high for 8 cycles, then `err` pulses once and one byte 0xEE is returned.
  - In a second run, an ack in cycle 8 returns data with no `err`.
- **Reset mid-SEND**: assert `rst` after byte 10 of a vector read.
  - All outputs immediately go to their reset values.
  - After release, a new scalar command completes correctly.
- **Ignored input**: `rx_valid` pulsed during REQ and SEND.
  - `rx_ready` stays 0 and the response is unchanged.
  - The next command, issued after IDLE, decodes correctly.

Source files
------------

// File: rtl/host_read_port.sv
// ============================================================================
//  Module      : host_read_port
//  Description : Byte-wide host responder. Takes a 3-byte read command,
//                issues one scalar or vector read on the shared memory port
//                and streams the returned line back one byte at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module host_read_port #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic                clk,
  input  logic                rst,
  // host command channel
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  // host response channel
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  // memory read port
  output logic                mem_req,
  output logic [17:0]         mem_addr,
  output logic                mem_vec,
  input  logic                mem_ack,
  input  logic [15:0][31:0]   mem_rdata,
  // status
  output logic                busy,
  output logic                err
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_HI  = 3'd1,
    ADDR_LO  = 3'd2,
    REQ      = 3'd3,
    SEND     = 3'd4,
    SEND_ERR = 3'd5
  } state_t;

  state_t             state;
  logic [17:0]        addr;
  logic               vec;
  logic [15:0][31:0]  line_buf;
  logic [5:0]         byte_cnt;
  logic [TO_W-1:0]    to_cnt;

  logic               rx_fire;
  logic               tx_fire;
  logic [5:0]         last_byte;

  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign last_byte = vec ? 6'd63 : 6'd3;

  // Address/vector latches drive the memory port directly; they only change
  // while a command is being received, so they are stable throughout REQ.
  assign mem_addr  = addr;
  assign mem_vec   = vec;

  // Byte k of a line: lane k/4, little-endian within the 32-bit word.
  function automatic logic [7:0] pick_byte(input logic [15:0][31:0] line,
                                           input logic [5:0]        k);
    logic [31:0] word;
    word = line[k[5:2]];
    return word[{k[1:0], 3'b000} +: 8];
  endfunction

  // Command decode, memory request, timeout and response streaming FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      vec      <= 1'b0;
      line_buf <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      rx_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // err is a single-cycle pulse, raised only on the abort edge
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            vec          <= rx_data[7];
            addr[17:16]  <= rx_data[1:0];
            busy         <= 1'b1;
            state        <= ADDR_HI;
          end
        end

        ADDR_HI: begin
          if (rx_fire) begin
            addr[15:8] <= rx_data;
            state      <= ADDR_LO;
          end
        end

        ADDR_LO: begin
          if (rx_fire) begin
            addr[7:0] <= rx_data;
            rx_ready  <= 1'b0;
            mem_req   <= 1'b1;
            to_cnt    <= '0;
            state     <= REQ;
          end
        end

        REQ: begin
          // An ack in the final timeout cycle still wins over the abort.
          if (mem_ack) begin
            line_buf <= mem_rdata;
            byte_cnt <= '0;
            tx_data  <= mem_rdata[0][7:0];
            tx_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= SEND;
          end else if (to_cnt == TO_LAST) begin
            mem_req  <= 1'b0;
            tx_data  <= ERR_BYTE;
            tx_valid <= 1'b1;
            err      <= 1'b1;
            state    <= SEND_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        SEND: begin
          if (tx_fire) begin
            if (byte_cnt == last_byte) begin
              tx_valid <= 1'b0;
              tx_data  <= '0;
              busy     <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 6'd1;
              tx_data  <= pick_byte(line_buf, byte_cnt + 6'd1);
            end
          end
        end

        SEND_ERR: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          tx_valid <= 1'b0;
          tx_data  <= '0;
          mem_req  <= 1'b0;
          busy     <= 1'b0;
          rx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_host_read_port.sv
// ============================================================================
//  Module      : tb_host_read_port
//  Description : Randomized self-checking bench for host_read_port with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_host_read_port;

  localparam int         T  = 8;
  localparam logic [7:0] EB = 8'hEE;

  logic               clk = 1'b0;
  logic               rst;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               mem_req;
  logic [17:0]        mem_addr;
  logic               mem_vec;
  logic               mem_ack;
  logic [15:0][31:0]  mem_rdata;
  logic               busy;
  logic               err;

  int checks = 0;
  int errors = 0;

  // reference memory line returned for the current command
  logic [31:0] lines [16];

  host_read_port #(
    .TIMEOUT_CYCLES (T),
    .ERR_BYTE       (EB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_vec   (mem_vec),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte k of the response is word k/4 shifted down by 8*(k%4).
  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    w = lines[k / 4] >> (8 * (k % 4));
    return w[7:0];
  endfunction

  task automatic rand_lines();
    for (int i = 0; i < 16; i++) lines[i] = $urandom;
  endtask

  // One full host transaction. ack_delay = index of the REQ cycle in which
  // memory acks (>= T means never). rmode: 0 ready high, 1 one-high/two-low,
  // 2 random. noise drives ignored rx/ack traffic. abort_after >= 0 returns
  // once that many response bytes have been transferred.
  task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int ack_delay, input int rmode, input bit noise,
                         input int abort_after);
    logic [17:0] ea;
    bit          ev;
    bit          acked;
    int          n;
    int          k;
    int          cyc;
    int          stall;
    logic [7:0]  cmd [3];
    ea  = {b0[1:0], b1, b2};
    ev  = b0[7];
    cmd = '{b0, b1, b2};

    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = cmd[i];
      check("rx_ready_cmd", rx_ready, 1);
      step();
    end
    rx_valid = 1'b0;
    rx_data  = '0;

    check("mem_addr", mem_addr, ea);
    check("mem_vec", mem_vec, ev);
    check("busy_req", busy, 1);
    check("rx_ready_req", rx_ready, 0);

    acked = 1'b0;
    for (int c = 0; c < T; c++) begin
      check("mem_req", mem_req, 1);
      check("mem_addr_hold", mem_addr, ea);
      if (noise) begin
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = 8'($urandom);
      end
      if (c == ack_delay) begin
        mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) mem_rdata[i] = lines[i];
      end
      step();
      mem_ack = 1'b0;
      if (c == ack_delay) begin
        acked = 1'b1;
        break;
      end
    end
    check("mem_req_off", mem_req, 0);

    n     = acked ? (ev ? 64 : 4) : 1;
    k     = 0;
    cyc   = 0;
    stall = 0;
    while (k < n) begin
      if (abort_after >= 0 && k == abort_after) return;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall >= 20) tx_ready = 1'b1;
      check("tx_valid", tx_valid, 1);
      check("tx_data", tx_data, acked ? exp_byte(k) : EB);
      check("err", err, (!acked && cyc == 0));
      if (noise) begin
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = 8'($urandom);
        mem_ack  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) mem_rdata[i] = $urandom;
        check("rx_ready_send", rx_ready, 0);
      end
      step();
      cyc++;
      if (tx_ready) begin
        k++;
        stall = 0;
      end else begin
        stall++;
      end
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    mem_ack  = 1'b0;
    check("busy_done", busy, 0);
    check("rx_ready_done", rx_ready, 1);
    check("tx_valid_done", tx_valid, 0);
    check("err_done", err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"},  tx_data,  0);
    check({tag, "_mem_req"},  mem_req,  0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_vec"},  mem_vec,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_err"},      err,      0);
  endtask

  // hard stop in case the DUT wedges somewhere no bounded loop covers
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = '0;
    tx_ready  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // scalar read: expect EF BE AD DE
    rand_lines();
    lines[0] = 32'hDEADBEEF;
    run_cmd(8'h02, 8'h12, 8'h34, 3, 0, 1'b0, -1);

    // vector read with ready high: byte k = k/4
    for (int i = 0; i < 16; i++) lines[i] = 32'h01010101 * i;
    run_cmd(8'h80, 8'h00, 8'h10, 1, 0, 1'b0, -1);

    // vector read under one-high/two-low backpressure
    rand_lines();
    run_cmd(8'h81, 8'hA5, 8'h5A, 0, 1, 1'b0, -1);

    // timeout: memory never acks
    run_cmd(8'h03, 8'hFF, 8'hFF, 1000, 0, 1'b0, -1);

    // ack in the final (8th) cycle wins
    rand_lines();
    run_cmd(8'h01, 8'h00, 8'h01, T - 1, 2, 1'b0, -1);

    // reset mid-SEND after 10 bytes of a vector read
    rand_lines();
    run_cmd(8'h80, 8'h22, 8'h33, 2, 0, 1'b0, 10);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rst      = 1'b0;
    tx_ready = 1'b0;
    step();
    rand_lines();
    run_cmd(8'h02, 8'h40, 8'h08, 0, 0, 1'b0, -1);

    // ignored rx_valid / mem_ack traffic during REQ and SEND, then clean command
    rand_lines();
    run_cmd(8'h80, 8'h01, 8'h02, 4, 2, 1'b1, -1);
    rand_lines();
    run_cmd(8'h7E, 8'hC3, 8'h3C, 2, 0, 1'b0, -1);

    // randomized commands, including timeouts
    for (int t = 0; t < 24; t++) begin
      rand_lines();
      run_cmd(8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, T + 1)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
